gf163_mult_seq: RTL and testbench



---
 rtl/gf163_pkg.sv | 33 +++
 rtl/gf163_reduce.sv | 28 ++
 rtl/karatsuba_mult_82.sv | 23 ++
 rtl/gf163_mult_seq.sv | 147 ++++++++++++++
 tb/tb_gf163_mult_seq.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/gf163_pkg.sv
// gf163_pkg: shared definitions for the GF(2^163) multiplier slice.
//   M        field degree (163)
//   P        half-operand width fed to the 82-bit multiplier
//   PW       unreduced product width (2M-1 = 325)
//   RED_POLY low part of f(x) = x^163 + x^7 + x^6 + x^3 + 1 (taps 0,3,6,7)
//   state_t  sequencer states
//   clmul41  41x41 carry-less product, the leaf of the Karatsuba split
package gf163_pkg;
    localparam int M  = 163;
    localparam int P  = 82;
    localparam int PW = 2 * M - 1;

    // Bit k set <=> x^k is a term of f(x) - x^163.
    localparam logic [7:0] RED_POLY = 8'b1100_1001;

    typedef enum logic [2:0] {
        IDLE,
        MUL_HH,
        MUL_LL,
        MUL_MID,
        REDUCE,
        DONE
    } state_t;

    function automatic logic [80:0] clmul41(input logic [40:0] x, input logic [40:0] y);
        logic [80:0] acc;
        acc = '0;
        for (int i = 0; i < 41; i++) begin
            if (y[i]) acc = acc ^ (81'(x) << i);
        end
        return acc;
    endfunction
endpackage

// File: rtl/gf163_reduce.sv
// gf163_reduce: combinational reduction of a 325-bit polynomial mod
// f(x) = x^163 + x^7 + x^6 + x^3 + 1 using two folds.
//   i_t  unreduced polynomial (degree <= 324)
//   o_c  reduced field element
module gf163_reduce
    import gf163_pkg::*;
(
    input  logic [PW-1:0] i_t,
    output logic [M-1:0]  o_c
);
    logic [M-2:0] w_h1;   // T[324:163], 162 bits
    logic [M+5:0] w_r1;   // 169 bits: first fold spills up to x^168
    logic [5:0]   w_h2;

    always_comb begin
        w_h1 = i_t[PW-1:M];
        w_r1 = {6'b0, i_t[M-1:0]};
        for (int k = 0; k < 8; k++) begin
            if (RED_POLY[k]) w_r1 = w_r1 ^ ({7'b0, w_h1} << k);
        end
        // Second fold: at most degree 12, never spills again.
        w_h2 = w_r1[M+5:M];
        o_c  = w_r1[M-1:0];
        for (int k = 0; k < 8; k++) begin
            if (RED_POLY[k]) o_c = o_c ^ (M'(w_h2) << k);
        end
    end
endmodule

// File: rtl/karatsuba_mult_82.sv
// karatsuba_mult_82: combinational 82x82 carry-less multiplier, one
// Karatsuba level over 41-bit halves.
//   i_a, i_b  82-bit polynomial operands
//   o_p       163-bit product (degree <= 162)
module karatsuba_mult_82
    import gf163_pkg::*;
(
    input  logic [81:0]  i_a,
    input  logic [81:0]  i_b,
    output logic [162:0] o_p
);
    logic [80:0] w_hh;
    logic [80:0] w_ll;
    logic [80:0] w_mid;

    always_comb begin
        w_hh  = clmul41(i_a[81:41], i_b[81:41]);
        w_ll  = clmul41(i_a[40:0],  i_b[40:0]);
        w_mid = clmul41(i_a[81:41] ^ i_a[40:0], i_b[81:41] ^ i_b[40:0]);
        // Cross term is mid ^ hh ^ ll in characteristic 2.
        o_p   = (163'(w_hh) << 82) ^ (163'(w_mid ^ w_hh ^ w_ll) << 41) ^ 163'(w_ll);
    end
endmodule

// File: rtl/gf163_mult_seq.sv
// gf163_mult_seq: sequential GF(2^163) multiplier. One 82-bit Karatsuba
// multiplier is reused over three cycles (hi*hi, lo*lo, mid*mid), then
// the recombined 325-bit product is reduced and registered into c.
// Optional macro GF163_SQUARE_EN adds the sq port: a squaring op skips
// the multiplier and reduces the bit-interleaved operand directly.
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    operand handshake (ready only in IDLE)
//   a, b                 163-bit operands, polynomial basis
//   sq                   squaring request (GF163_SQUARE_EN only)
//   out_valid/out_ready  result handshake
//   c                    A*B mod f(x)
module gf163_mult_seq
    import gf163_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [M-1:0] a,
    input  logic [M-1:0] b,
`ifdef GF163_SQUARE_EN
    input  logic         sq,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [M-1:0] c
);
    state_t       r_state, w_next;
    logic [M-1:0] r_a, r_b;
    logic [M-1:0] r_p_hh, r_p_ll, r_p_mid;
    logic [M-1:0] r_c;
    logic         r_out_valid;

    logic [P-1:0]  w_ma, w_mb;
    logic [M-1:0]  w_prod;
    logic [PW-1:0] w_t;
    logic [M-1:0]  w_red;
    logic          w_accept;
    logic          w_sq_go;

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign c         = r_c;
    assign w_accept  = in_valid && (r_state == IDLE);

`ifdef GF163_SQUARE_EN
    logic          r_sq;
    logic [PW-1:0] w_t_sq;
    assign w_sq_go = sq;

    // Squaring in GF(2): coefficient i of a lands on x^(2i).
    always_comb begin
        w_t_sq = '0;
        for (int i = 0; i < M; i++) w_t_sq[2*i] = r_a[i];
    end
`else
    assign w_sq_go = 1'b0;
`endif

    // Multiplier operand mux; the high half is zero-extended to 82 bits.
    always_comb begin
        w_ma = r_a[P-1:0];
        w_mb = r_b[P-1:0];
        case (r_state)
            MUL_HH: begin
                w_ma = {1'b0, r_a[M-1:P]};
                w_mb = {1'b0, r_b[M-1:P]};
            end
            MUL_MID: begin
                w_ma = {1'b0, r_a[M-1:P]} ^ r_a[P-1:0];
                w_mb = {1'b0, r_b[M-1:P]} ^ r_b[P-1:0];
            end
            default: ;
        endcase
    end

    karatsuba_mult_82 u_kmul (
        .i_a (w_ma),
        .i_b (w_mb),
        .o_p (w_prod)
    );

    // Recombine: A*B = Phh x^164 + (Pmid^Phh^Pll) x^82 + Pll.
    always_comb begin
        w_t = (PW'(r_p_hh) << (2 * P)) ^ (PW'(r_p_mid ^ r_p_hh ^ r_p_ll) << P) ^ PW'(r_p_ll);
`ifdef GF163_SQUARE_EN
        if (r_sq) w_t = w_t_sq;
`endif
    end

    gf163_reduce u_red (
        .i_t (w_t),
        .o_c (w_red)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_sq_go ? REDUCE : MUL_HH;
            MUL_HH:  w_next = MUL_LL;
            MUL_LL:  w_next = MUL_MID;
            MUL_MID: w_next = REDUCE;
            REDUCE:  w_next = DONE;
            DONE:    if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_p_hh      <= '0;
            r_p_ll      <= '0;
            r_p_mid     <= '0;
            r_c         <= '0;
            r_out_valid <= 1'b0;
`ifdef GF163_SQUARE_EN
            r_sq        <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_a <= a;
                r_b <= b;
`ifdef GF163_SQUARE_EN
                r_sq <= sq;
`endif
            end
            case (r_state)
                MUL_HH:  r_p_hh  <= w_prod;
                MUL_LL:  r_p_ll  <= w_prod;
                MUL_MID: r_p_mid <= w_prod;
                REDUCE: begin
                    r_c         <= w_red;
                    r_out_valid <= 1'b1;
                end
                DONE:    if (out_ready) r_out_valid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gf163_mult_seq.sv
module tb_gf163_mult_seq;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [162:0] a = '0;
    logic [162:0] b = '0;
    logic         sq = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [162:0] c;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gf163_mult_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef GF163_SQUARE_EN
        .sq        (sq),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c)
    );

    // Reference: schoolbook carry-less product then long division by f(x).
    function automatic logic [162:0] ref_mul(input logic [162:0] x, input logic [162:0] y);
        logic [324:0] t;
        logic [324:0] f;
        t = '0;
        f = '0;
        f[163] = 1'b1; f[7] = 1'b1; f[6] = 1'b1; f[3] = 1'b1; f[0] = 1'b1;
        for (int i = 0; i < 163; i++)
            if (y[i]) t = t ^ (325'(x) << i);
        for (int i = 324; i >= 163; i--)
            if (t[i]) t = t ^ (f << (i - 163));
        return t[162:0];
    endfunction

    function automatic logic [162:0] rnd163();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [162:0] obs, input logic [162:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one op, check ready/valid each cycle until the result edge,
    // then check c. Leaves the DUT in DONE (result not yet consumed).
    task automatic issue(input logic [162:0] ta, input logic [162:0] tb_v, input logic tsq,
                         input int lat, input logic [162:0] exp, input string tag);
        @(negedge clk);
        chk({tag, ".rdy_pre"}, 163'(in_ready), 163'd1);
        in_valid = 1'b1; a = ta; b = tb_v; sq = tsq;
        @(posedge clk);                 // E0
        @(negedge clk);
        in_valid = 1'b0; a = rnd163(); b = rnd163();
        for (int k = 0; k < lat; k++) begin
            if (k > 0) @(negedge clk);
            chk({tag, ".rdy_busy"}, 163'(in_ready), 163'd0);
            chk({tag, ".vld_early"}, 163'(out_valid), 163'd0);
        end
        @(negedge clk);                 // after E(lat)
        chk({tag, ".vld"}, 163'(out_valid), 163'd1);
        chk({tag, ".c"}, c, exp);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".vld_drop"}, 163'(out_valid), 163'd0);
        chk({tag, ".rdy_back"}, 163'(in_ready), 163'd1);
    endtask

    initial begin
        logic [162:0] x, y, exp;
        logic         s;

        // Reset state
        #2;
        chk("rst.vld", 163'(out_valid), 163'd0);
        chk("rst.c", c, 163'd0);
        chk("rst.rdy", 163'(in_ready), 163'd1);
        @(negedge clk); rst_n = 1'b1;

        // 1*1, with out_ready held high early (must have no effect)
        out_ready = 1'b1;
        issue(163'd1, 163'd1, 1'b0, 4, 163'd1, "one");
        consume("one");

        // x^162 * x -> first fold
        x = 163'd1 << 162; y = 163'd1 << 1;
        issue(x, y, 1'b0, 4, 163'hC9, "fold");
        consume("fold");

        // x^82 * x^81 -> mid cross term
        x = 163'd1 << 82; y = 163'd1 << 81;
        issue(x, y, 1'b0, 4, 163'hC9, "mid");
        consume("mid");

        // Backpressure: result held, new operands ignored
        x = rnd163(); y = rnd163(); exp = ref_mul(x, y);
        issue(x, y, 1'b0, 4, exp, "bp");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            in_valid = (k % 3) == 0; a = rnd163(); b = rnd163();
            chk("bp.c_hold", c, exp);
            chk("bp.vld_hold", 163'(out_valid), 163'd1);
            chk("bp.rdy_low", 163'(in_ready), 163'd0);
        end
        in_valid = 1'b0;
        consume("bp");

        // Reset during MUL_LL
        @(negedge clk);
        in_valid = 1'b1; a = rnd163(); b = rnd163(); sq = 1'b0;
        @(posedge clk);                 // E0 -> MUL_HH
        @(negedge clk); in_valid = 1'b0;
        @(posedge clk);                 // E1 -> MUL_LL
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst.vld", 163'(out_valid), 163'd0);
        chk("mrst.c", c, 163'd0);
        chk("mrst.rdy", 163'(in_ready), 163'd1);
        @(negedge clk); rst_n = 1'b1;
        issue(163'd3, 163'd3, 1'b0, 4, 163'd5, "post_rst");
        consume("post_rst");

`ifdef GF163_SQUARE_EN
        x = 163'd1 << 100;
        exp = (163'd1 << 44) | (163'd1 << 43) | (163'd1 << 40) | (163'd1 << 37);
        issue(x, rnd163(), 1'b1, 1, exp, "sq100");
        consume("sq100");
`endif

        // Random ops against the reference model
        for (int n = 0; n < 1000; n++) begin
            x = rnd163(); y = rnd163(); s = 1'b0;
`ifdef GF163_SQUARE_EN
            s = $urandom_range(0, 3) == 0;
`endif
            if (s) begin
                exp = ref_mul(x, x);
                issue(x, y, 1'b1, 1, exp, "rnd_sq");
            end else begin
                exp = ref_mul(x, y);
                issue(x, y, 1'b0, 4, exp, "rnd");
            end
            consume("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
